tx_fifo_rr_sched: RTL and testbench

Round-robin read scheduler for NUM_CH transmit FIFOs that share one output datapath. It sits on the read side of the per-channel async FIFO controllers and decides which channel pops. It drains the granted channel in bursts of up to BURST_MAX words and forwards them onto a single valid/ready stream, tagging each word with its channel number and a first-of-burst marker. A 2-entry output buffer absorbs the one-cycle FIFO RAM read latency, so the stream runs at full throughput without dropping words under backpressure.

---
 rtl/tx_fifo_rr_sched.sv | 158 +++++++++++++++
 tb/tb_tx_fifo_rr_sched.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_fifo_rr_sched.sv
// Round-robin burst read scheduler: drains NUM_CH FIFOs onto one valid/ready stream.
// Pop-to-output is 2 cycles; a 2-entry output buffer plus credit gating stalls pops under backpressure.
module tx_fifo_rr_sched #(
   parameter int NUM_CH     = 4,
   parameter int DATA_WIDTH = 8,
   parameter int BURST_MAX  = 16,
   parameter int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                         i_clk,
   input  logic                         i_rst,
   input  logic [NUM_CH-1:0]            i_empty,
   output logic [NUM_CH-1:0]            o_pop,
   input  logic [NUM_CH*DATA_WIDTH-1:0] i_rdata,
   output logic                         o_valid,
   input  logic                         i_ready,
   output logic [DATA_WIDTH-1:0]        o_data,
   output logic [CH_W-1:0]              o_chan,
   output logic                         o_first,
   output logic                         o_busy
);

   localparam int CNT_W = $clog2(BURST_MAX + 1);

   localparam logic [0:0] S_IDLE  = 1'b0;
   localparam logic [0:0] S_BURST = 1'b1;

   logic [0:0]            state_q, state_d;
   logic [CH_W-1:0]       grant_q, grant_d;
   logic [CH_W-1:0]       rr_ptr_q, rr_ptr_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  first_q, first_d;

   logic                  infl_q;
   logic [CH_W-1:0]       infl_ch_q;
   logic                  infl_first_q;

   logic [DATA_WIDTH-1:0] buf_dat_q   [2];
   logic [CH_W-1:0]       buf_ch_q    [2];
   logic                  buf_first_q [2];
   logic                  rd_q, wr_q;
   logic [1:0]            occ_q, occ_d;

   logic                  deq;
   logic [2:0]            cred_sum;
   logic                  credit;
   logic                  gnt_empty;
   logic                  pop_en;
   logic                  last_pop;
   logic                  burst_end;
   logic [CH_W-1:0]       arb_sel;
   logic [DATA_WIDTH-1:0] rd_word;

   // Modulo add that stays correct for non-power-of-2 channel counts.
   function automatic logic [CH_W-1:0] wrap_add(input logic [CH_W-1:0] base, input int off);
      int s;
      s = int'(base) + off;
      if (s >= NUM_CH) s = s - NUM_CH;
      return CH_W'(s);
   endfunction

   assign deq       = o_valid & i_ready;
   assign cred_sum  = {1'b0, occ_q} + {2'b00, infl_q} - {2'b00, deq};
   assign credit    = cred_sum < 3'd2;
   assign gnt_empty = i_empty[grant_q];
   assign pop_en    = (state_q == S_BURST) && !gnt_empty && credit;
   assign last_pop  = pop_en && (cnt_q == CNT_W'(BURST_MAX - 1));
   assign burst_end = (state_q == S_BURST) && (gnt_empty || last_pop);
   assign o_pop     = pop_en ? (NUM_CH'(1) << grant_q) : '0;

   // Descending scan so the smallest offset from rr_ptr wins.
   always_comb begin
      arb_sel = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (!i_empty[wrap_add(rr_ptr_q, i)]) arb_sel = wrap_add(rr_ptr_q, i);
      end
   end

   always_comb begin
      rd_word = '0;
      for (int n = 0; n < NUM_CH; n++) begin
         if (infl_ch_q == CH_W'(n)) rd_word = i_rdata[n*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   always_comb begin
      state_d  = state_q;
      grant_d  = grant_q;
      rr_ptr_d = rr_ptr_q;
      cnt_d    = cnt_q;
      first_d  = first_q;
      case (state_q)
         S_IDLE: begin
            if (|(~i_empty)) begin
               grant_d = arb_sel;
               cnt_d   = '0;
               first_d = 1'b1;
               state_d = S_BURST;
            end
         end
         default: begin
            if (pop_en) begin
               cnt_d   = cnt_q + CNT_W'(1);
               first_d = 1'b0;
            end
            if (burst_end) begin
               state_d  = S_IDLE;
               rr_ptr_d = wrap_add(grant_q, 1);
            end
         end
      endcase
   end

   assign occ_d = occ_q + {1'b0, infl_q} - {1'b0, deq};

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q      <= S_IDLE;
         grant_q      <= '0;
         rr_ptr_q     <= '0;
         cnt_q        <= '0;
         first_q      <= 1'b0;
         infl_q       <= 1'b0;
         infl_ch_q    <= '0;
         infl_first_q <= 1'b0;
         rd_q         <= 1'b0;
         wr_q         <= 1'b0;
         occ_q        <= 2'd0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         rr_ptr_q     <= rr_ptr_d;
         cnt_q        <= cnt_d;
         first_q      <= first_d;
         infl_q       <= pop_en;
         infl_ch_q    <= grant_q;
         infl_first_q <= first_q;
         occ_q        <= occ_d;
         if (infl_q) wr_q <= ~wr_q;
         if (deq)    rd_q <= ~rd_q;
      end
   end

   // Storage needs no reset: occupancy alone decides what is visible.
   always_ff @(posedge i_clk) begin
      if (infl_q) begin
         buf_dat_q[wr_q]   <= rd_word;
         buf_ch_q[wr_q]    <= infl_ch_q;
         buf_first_q[wr_q] <= infl_first_q;
      end
   end

   assign o_valid = (occ_q != 2'd0);
   assign o_data  = o_valid ? buf_dat_q[rd_q]   : '0;
   assign o_chan  = o_valid ? buf_ch_q[rd_q]    : '0;
   assign o_first = o_valid ? buf_first_q[rd_q] : 1'b0;
   assign o_busy  = (state_q == S_BURST) || o_valid || infl_q;

endmodule

// File: tb/tb_tx_fifo_rr_sched.sv
// Directed bench for tx_fifo_rr_sched with behavioural FIFOs and an output scoreboard.
module tb_tx_fifo_rr_sched;
   localparam int NCH = 4;
   localparam int DW  = 8;
   localparam int BM  = 16;

   logic            clk = 1'b0;
   logic            i_rst;
   logic [NCH-1:0]  i_empty;
   logic [NCH-1:0]  o_pop;
   logic [NCH*DW-1:0] i_rdata;
   logic            o_valid;
   logic            i_ready;
   logic [DW-1:0]   o_data;
   logic [1:0]      o_chan;
   logic            o_first;
   logic            o_busy;

   always #5 clk = ~clk;

   tx_fifo_rr_sched #(.NUM_CH(NCH), .DATA_WIDTH(DW), .BURST_MAX(BM)) dut (
      .i_clk(clk), .i_rst(i_rst), .i_empty(i_empty), .o_pop(o_pop), .i_rdata(i_rdata),
      .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data), .o_chan(o_chan),
      .o_first(o_first), .o_busy(o_busy)
   );

   int nchecks = 0;
   int nerrors = 0;
   int cyc = 0;
   always @(posedge clk) cyc++;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nchecks++;
      assert (obs === exp) else begin
         nerrors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Behavioural FIFOs: pop seen in cycle t presents its word during t+1.
   logic [7:0] fmem [NCH][256];
   int head [NCH];
   int tail [NCH];
   logic [NCH-1:0] pop_seen = '0;

   task automatic upd_empty();
      for (int n = 0; n < NCH; n++) i_empty[n] = (head[n] == tail[n]);
   endtask

   task automatic load(input int ch, input int cnt, input int base);
      for (int k = 0; k < cnt; k++) begin
         fmem[ch][tail[ch]] = {2'(ch), 6'(base + k)};
         tail[ch]++;
      end
      upd_empty();
   endtask

   always @(negedge clk) pop_seen = o_pop;

   always @(posedge clk) begin
      #1;
      for (int n = 0; n < NCH; n++) begin
         if (pop_seen[n] === 1'b1 && head[n] != tail[n]) begin
            i_rdata[n*DW +: DW] = fmem[n][head[n]];
            head[n]++;
         end
      end
      upd_empty();
   end

   typedef struct packed {
      logic [7:0] d;
      logic [1:0] c;
      logic       f;
   } exp_t;
   exp_t exp_q[$];
   int rr_model = 0;

   // Expected order: round-robin from rr_model, bursts capped at BM words.
   task automatic predict();
      int rem [NCH];
      int pos [NCH];
      int p, n, b;
      exp_t e;
      p = rr_model;
      for (int i = 0; i < NCH; i++) begin
         rem[i] = tail[i] - head[i];
         pos[i] = head[i];
      end
      while (rem[0] + rem[1] + rem[2] + rem[3] > 0) begin
         n = 0;
         for (int i = NCH - 1; i >= 0; i--) if (rem[(p + i) % NCH] > 0) n = (p + i) % NCH;
         b = (rem[n] > BM) ? BM : rem[n];
         for (int k = 0; k < b; k++) begin
            e.d = fmem[n][pos[n] + k];
            e.c = 2'(n);
            e.f = (k == 0);
            exp_q.push_back(e);
         end
         pos[n] += b;
         rem[n] -= b;
         p = (n + 1) % NCH;
      end
      rr_model = p;
   endtask

   int first_pop_cyc, last_pop_cyc, pop_cnt, pop128_cyc, first_out_cyc, stall_pops;
   int popc [NCH];
   logic stall_win = 1'b0;
   logic pv_stall = 1'b0;
   logic [7:0] pd;
   logic [1:0] pc;
   logic pf;

   task automatic clear_marks();
      first_pop_cyc = -1; last_pop_cyc = -1; pop_cnt = 0; pop128_cyc = -1;
      first_out_cyc = -1; stall_pops = 0;
      for (int n = 0; n < NCH; n++) popc[n] = 0;
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (i_rst === 1'b0 && cyc > 0) begin
         if (o_pop != '0) begin
            check("pop_legal", 32'(((o_pop & i_empty) == '0) && $onehot(o_pop)), 1);
            pop_cnt++;
            if (first_pop_cyc < 0) first_pop_cyc = cyc;
            last_pop_cyc = cyc;
            if (pop_cnt == 128) pop128_cyc = cyc;
            if (stall_win) stall_pops++;
            for (int n = 0; n < NCH; n++) if (o_pop[n]) popc[n]++;
         end
         if (pv_stall) check("bp_hold", {o_valid, o_data, o_chan, o_first}, {1'b1, pd, pc, pf});
         if (o_valid && i_ready) begin
            if (first_out_cyc < 0) first_out_cyc = cyc;
            check("sb_has_entry", 32'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               check("sb_word", {o_data, o_chan, o_first}, {e.d, e.c, e.f});
            end
         end
         pv_stall = o_valid && !i_ready;
         pd = o_data; pc = o_chan; pf = o_first;
      end else begin
         pv_stall = 1'b0;
      end
   end

   task automatic wait_pop(input logic [NCH-1:0] want);
      int t = 0;
      @(negedge clk);
      while (((want == '0) ? (o_pop == '0) : (o_pop != want)) && t < 300) begin
         @(negedge clk);
         t++;
      end
      check("pop_wait_timeout", 32'(t < 300), 1);
   endtask

   task automatic drain();
      int t = 0;
      while ((exp_q.size() != 0 || o_busy !== 1'b0) && t < 3000) begin
         @(negedge clk);
         t++;
      end
      check("drain_timeout", 32'(t < 3000), 1);
      check("drain_sb_empty", exp_q.size(), 0);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      i_rst = 1'b1;
      i_ready = 1'b1;
      i_rdata = '0;
      for (int n = 0; n < NCH; n++) begin head[n] = 0; tail[n] = 0; end
      clear_marks();
      for (int n = 0; n < NCH; n++) load(n, 1, 0);

      // Reset with all FIFOs holding data.
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("rst_pop", o_pop, 0);
         check("rst_valid", o_valid, 0);
      end
      check("rst_outputs", {o_data, o_chan, o_first, o_busy}, 0);
      rr_model = 0;
      predict();
      @(posedge clk); #2;
      i_rst = 1'b0;
      wait_pop('0);
      check("rst_first_grant", o_pop, 4'b0001);
      drain();

      // Round robin with burst cap, 40 words per channel.
      clear_marks();
      @(posedge clk); #2;
      for (int n = 0; n < NCH; n++) load(n, 40, 0);
      predict();
      drain();
      check("rr_pops", pop_cnt, 160);
      check("rr_span_8_bursts", pop128_cyc - first_pop_cyc, 134);

      // Single 3-word burst on channel 1.
      clear_marks();
      @(posedge clk); #2;
      load(1, 3, 0);
      predict();
      drain();
      check("sb_pops", pop_cnt, 3);
      check("sb_consecutive", last_pop_cyc - first_pop_cyc, 2);
      check("sb_latency", first_out_cyc - first_pop_cyc, 2);

      // Early empty on channel 2, then channel 3.
      clear_marks();
      @(posedge clk); #2;
      load(2, 5, 0);
      load(3, 20, 0);
      predict();
      drain();
      check("ee_ch2_pops", popc[2], 5);
      check("ee_ch3_pops", popc[3], 20);

      // Backpressure mid-burst.
      clear_marks();
      @(posedge clk); #2;
      load(0, 20, 0);
      predict();
      wait_pop('0);
      repeat (4) @(posedge clk);
      #2 i_ready = 1'b0;
      repeat (2) @(posedge clk);
      #2 stall_win = 1'b1;
      repeat (4) @(posedge clk);
      #2 stall_win = 1'b0;
      i_ready = 1'b1;
      check("bp_no_pop_stalled", stall_pops, 0);
      drain();
      check("bp_pops", pop_cnt, 20);

      // Reset during a channel-0 burst.
      clear_marks();
      @(posedge clk); #2;
      load(0, 20, 32);
      load(1, 4, 32);
      predict();
      wait_pop(4'b0001);
      repeat (3) @(posedge clk);
      #2 i_rst = 1'b1;
      @(posedge clk); #2;
      i_rst = 1'b0;
      exp_q.delete();
      load(1, 4, 48);
      rr_model = 0;
      predict();
      @(negedge clk);
      check("mid_rst_valid", o_valid, 0);
      check("mid_rst_busy", o_busy, 0);
      wait_pop('0);
      check("mid_rst_restart_grant", o_pop, 4'b0001);
      drain();

      $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
      $finish;
   end
endmodule
